// File: rtl/ata_pio_ctl_if.sv
// Host-side request/response handshake between the RK11 register block and
// the ATA PIO timing engine.
interface ata_pio_ctl_if;
    logic        ata_rd;
    logic        ata_wr;
    logic [4:0]  ata_addr;
    logic [15:0] ata_in;
    logic [15:0] ata_out;
    logic        ata_done;

    modport master (output ata_rd, ata_wr, ata_addr, ata_in,
                    input  ata_out, ata_done);
    modport slave  (input  ata_rd, ata_wr, ata_addr, ata_in,
                    output ata_out, ata_done);
endinterface

// File: rtl/ata_pio_ctl.sv
// ATA PIO-mode-0 timing engine: turns one level-held register request into a
// timed DIOR-/DIOW- cycle on the IDE connector and pulses ata_done.
// Optional macro IDE_IORDY_EN adds IORDY-based strobe extension.
module ata_pio_ctl #(
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 15,
    parameter int T_HOLD      = 2,
    parameter int T_RECOV     = 12
`ifdef IDE_IORDY_EN
    ,parameter int T_IORDY_MAX = 625
`endif
) (
    input  logic         clk,
    input  logic         reset_n,
    ata_pio_ctl_if.slave host,
    inout  wire  [15:0]  ide_data_bus,
    output logic         ide_dior,
    output logic         ide_diow,
    output logic [1:0]   ide_cs,
    output logic [2:0]   ide_da
`ifdef IDE_IORDY_EN
    ,input logic         ide_iordy
`endif
);
    // zero-valued timing parameters are clamped to one cycle
    localparam int S_N = (T_SETUP < 1) ? 1 : T_SETUP;
    localparam int P_N = (T_PULSE < 1) ? 1 : T_PULSE;
    localparam int H_N = (T_HOLD  < 1) ? 1 : T_HOLD;
    localparam int R_N = (T_RECOV < 1) ? 1 : T_RECOV;
    localparam int M_A = (S_N > P_N) ? S_N : P_N;
    localparam int M_B = (H_N > R_N) ? H_N : R_N;
    localparam int MAXP = (M_A > M_B) ? M_A : M_B;
    localparam int CW  = $clog2(MAXP + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, RECOV} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rd;
    logic [15:0]   r_wdata;
    logic [15:0]   r_cap;
    logic [15:0]   r_out;
    logic          r_done;
    logic          r_oe;
    logic          w_strobe_end;
    logic          w_tmo;

`ifdef IDE_IORDY_EN
    localparam int I_N = (T_IORDY_MAX < 1) ? 1 : T_IORDY_MAX;
    localparam int EW  = $clog2(I_N + 1);
    logic [1:0]    r_iordy_s;
    logic [EW-1:0] r_ext;
    logic          r_tmo;

    // two-flop synchronizer for the asynchronous IORDY pin
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_iordy_s <= 2'b00;
        else          r_iordy_s <= {r_iordy_s[0], ide_iordy};

    assign w_tmo        = !r_iordy_s[1] && (r_ext == EW'(I_N - 1));
    assign w_strobe_end = (r_cnt == '0) && (r_iordy_s[1] || w_tmo);
`else
    assign w_tmo        = 1'b0;
    assign w_strobe_end = (r_cnt == '0);
`endif

    assign ide_data_bus  = r_oe ? r_wdata : 16'hzzzz;
    assign host.ata_out  = r_out;
    assign host.ata_done = r_done;

    // Phase sequencer; every pin is registered and set on entry to its phase.
    // RECOV lasts R_N-1 cycles so that, together with the IDLE sampling
    // cycle, exactly R_N idle cycles separate ata_done from the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rd     <= 1'b0;
            r_wdata  <= '0;
            r_cap    <= '0;
            r_out    <= '0;
            r_done   <= 1'b0;
            r_oe     <= 1'b0;
            ide_dior <= 1'b1;
            ide_diow <= 1'b1;
            ide_cs   <= 2'b11;
            ide_da   <= 3'b000;
`ifdef IDE_IORDY_EN
            r_ext    <= '0;
            r_tmo    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (host.ata_rd || host.ata_wr) begin
                    r_state <= SETUP;
                    r_cnt   <= CW'(S_N - 1);
                    r_rd    <= host.ata_rd;          // read wins a tie
                    r_wdata <= host.ata_in;
                    r_oe    <= !host.ata_rd;
                    ide_cs  <= {~host.ata_addr[3], ~host.ata_addr[4]};
                    ide_da  <= host.ata_addr[2:0];
`ifdef IDE_IORDY_EN
                    r_ext   <= '0;
                    r_tmo   <= 1'b0;
`endif
                end
                SETUP: if (r_cnt == '0) begin
                    r_state  <= STROBE;
                    r_cnt    <= CW'(P_N - 1);
                    ide_dior <= !r_rd;
                    ide_diow <= r_rd;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                STROBE: begin
                    if (r_rd) r_cap <= ide_data_bus;  // last strobe cycle wins
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_strobe_end) begin
                        r_state  <= HOLD;
                        r_cnt    <= CW'(H_N - 1);
                        ide_dior <= 1'b1;
                        ide_diow <= 1'b1;
`ifdef IDE_IORDY_EN
                        r_tmo    <= w_tmo;
`endif
                    end
`ifdef IDE_IORDY_EN
                    else begin
                        r_ext <= r_ext + 1'b1;
                    end
`endif
                end
                HOLD: if (r_cnt == '0) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_oe    <= 1'b0;
                    ide_cs  <= 2'b11;
                    ide_da  <= 3'b000;
`ifdef IDE_IORDY_EN
                    if (r_rd) r_out <= r_tmo ? 16'hFFFF : r_cap;
`else
                    if (r_rd) r_out <= r_cap;
`endif
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                DONE: if (R_N > 1) begin
                    r_state <= RECOV;
                    r_cnt   <= CW'(R_N - 2);
                end else begin
                    r_state <= IDLE;
                end
                RECOV: if (r_cnt == '0) r_state <= IDLE;
                       else             r_cnt   <= r_cnt - 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = w_tmo;
endmodule

// File: tb/tb_ata_pio_ctl.sv
// Scoreboard bench for ata_pio_ctl: stimulus pushes expected transactions,
// a negedge monitor profiles the IDE pins and checks each one on ata_done.
module tb_ata_pio_ctl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ata_pio_ctl_if bus_if();
    tri1 [15:0] ide_data_bus;
    logic       ide_dior, ide_diow;
    logic [1:0] ide_cs;
    logic [2:0] ide_da;
    logic [15:0] dev_data = 16'h0000;

    // device model drives the bus only while DIOR- is low; released bus reads FFFF
    assign ide_data_bus = ide_dior ? 16'hzzzz : dev_data;

    ata_pio_ctl dut (
        .clk(clk), .reset_n(reset_n), .host(bus_if),
        .ide_data_bus(ide_data_bus), .ide_dior(ide_dior), .ide_diow(ide_diow),
        .ide_cs(ide_cs), .ide_da(ide_da)
`ifdef IDE_IORDY_EN
        ,.ide_iordy(1'b1)
`endif
    );

    typedef struct {
        int          start;
        bit          rd;
        logic [1:0]  cs;
        logic [2:0]  da;
        logic [15:0] wd;
        logic [15:0] out;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   abort = 1'b0;
    logic [15:0] exp_out = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: per-transaction pin profile, checked and popped on ata_done
    initial begin
        int n_r, f_r, l_r, n_w, f_w, l_w, n_d, f_d, l_d, bad, rel;
        bit drv;
        exp_t e;
        n_r = 0; f_r = -1; l_r = -1; n_w = 0; f_w = -1; l_w = -1;
        n_d = 0; f_d = -1; l_d = -1; bad = 0;
        forever begin
            @(negedge clk);
            drv = ide_dior && (ide_data_bus !== 16'hFFFF);
            if (!reset_n) continue;
            if (q.size() == 0) begin
                if (bus_if.ata_done) chk("unexpected_done", 1, 0);
                else if (!abort && (!ide_dior || !ide_diow || drv))
                    chk("stray_activity", {ide_dior, ide_diow, drv}, 3'b110);
                continue;
            end
            e = q[0];
            rel = cyc - e.start;
            if (rel >= 1 && rel <= 21 && (ide_cs !== e.cs || ide_da !== e.da)) bad++;
            if (!ide_dior) begin
                n_r++; if (f_r < 0) f_r = rel; l_r = rel;
                if (ide_data_bus !== dev_data) bad++;
            end
            if (!ide_diow) begin
                n_w++; if (f_w < 0) f_w = rel; l_w = rel;
            end
            if (drv) begin
                n_d++; if (f_d < 0) f_d = rel; l_d = rel;
                if (ide_data_bus !== e.wd) bad++;
            end
            if (bus_if.ata_done) begin
                chk("latency", rel, 22);
                chk("ata_out", bus_if.ata_out, e.out);
                chk("cs_da_at_done", {ide_cs, ide_da}, 5'b11000);
                chk("dior_count", n_r, e.rd ? 15 : 0);
                chk("dior_first", f_r, e.rd ? 5 : -1);
                chk("dior_last",  l_r, e.rd ? 19 : -1);
                chk("diow_count", n_w, e.rd ? 0 : 15);
                chk("diow_first", f_w, e.rd ? -1 : 5);
                chk("diow_last",  l_w, e.rd ? -1 : 19);
                chk("drive_count", n_d, e.rd ? 0 : 21);
                chk("drive_first", f_d, e.rd ? -1 : 1);
                chk("drive_last",  l_d, e.rd ? -1 : 21);
                chk("pin_values", bad, 0);
                void'(q.pop_front());
                n_r = 0; f_r = -1; l_r = -1; n_w = 0; f_w = -1; l_w = -1;
                n_d = 0; f_d = -1; l_d = -1; bad = 0;
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // one access: request held for 'hold' cycles, next slot 34 cycles later
    task automatic access(input bit rd, input bit wr, input logic [4:0] addr,
                          input logic [15:0] din, input logic [15:0] dev, input int hold);
        exp_t e;
        int c;
        @(negedge clk);
        c = cyc;
        dev_data = dev;
        bus_if.ata_rd = rd; bus_if.ata_wr = wr;
        bus_if.ata_addr = addr; bus_if.ata_in = din;
        if (rd) exp_out = dev;
        e.start = c; e.rd = rd; e.cs = {~addr[3], ~addr[4]}; e.da = addr[2:0];
        e.wd = din; e.out = exp_out;
        q.push_back(e);
        wait_cyc(c + hold);
        bus_if.ata_rd = 1'b0; bus_if.ata_wr = 1'b0;
        wait_cyc(c + 34);
        chk("access_complete", q.size(), 0);
        q.delete();
    endtask

    initial begin
        exp_t e;
        int c;
        bus_if.ata_rd = 1'b0; bus_if.ata_wr = 1'b0;
        bus_if.ata_addr = 5'd0; bus_if.ata_in = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_strobes", {ide_dior, ide_diow}, 2'b11);
        chk("rst_cs_da", {ide_cs, ide_da}, 5'b11000);
        chk("rst_done", bus_if.ata_done, 0);
        chk("rst_out", bus_if.ata_out, 16'h0000);
        chk("rst_bus", ide_data_bus, 16'hFFFF);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        access(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h0050, 22);  // read STATUS
        access(1'b0, 1'b1, 5'b01110, 16'h0002, 16'h0000, 22);  // write DEVCTRL
        access(1'b1, 1'b1, 5'b10000, 16'hBEEF, 16'h8001, 22);  // rd+wr -> read
        access(1'b1, 1'b0, 5'b10001, 16'h0000, 16'hC37E, 1);   // request dropped early
        access(1'b0, 1'b1, 5'b10000, 16'h1234, 16'h0000, 22);  // data write

        // held read: exactly one access per 34 cycles
        @(negedge clk);
        c = cyc;
        dev_data = 16'hA5C3;
        bus_if.ata_rd = 1'b1; bus_if.ata_addr = 5'b10111;
        exp_out = 16'hA5C3;
        e.rd = 1'b1; e.cs = 2'b10; e.da = 3'b111; e.wd = 16'h0; e.out = 16'hA5C3;
        e.start = c;      q.push_back(e);
        e.start = c + 34; q.push_back(e);
        wait_cyc(c + 40);
        bus_if.ata_rd = 1'b0;
        wait_cyc(c + 68);
        chk("held_complete", q.size(), 0);
        q.delete();

        // reset during STROBE of a write
        abort = 1'b1;
        @(negedge clk);
        c = cyc;
        bus_if.ata_wr = 1'b1; bus_if.ata_addr = 5'b10000; bus_if.ata_in = 16'h5A5A;
        wait_cyc(c + 10);
        chk("pre_abort_diow", ide_diow, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_strobes", {ide_dior, ide_diow}, 2'b11);
        chk("abort_cs_da", {ide_cs, ide_da}, 5'b11000);
        chk("abort_bus", ide_data_bus, 16'hFFFF);
        chk("abort_out", bus_if.ata_out, 16'h0000);
        @(negedge clk);
        bus_if.ata_wr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        abort = 1'b0;
        exp_out = 16'h0000;
        access(1'b0, 1'b1, 5'b01110, 16'h0004, 16'h0000, 22);  // write after reset
        access(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h00D0, 22);  // read after reset

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
